// File: rtl/count_ctrl.sv
// count_ctrl: debounced run/dir buttons driving a
// prescaled step strobe for a downstream 0-9 counter.
//   clki      : system clock, rising edge
//   reset_n   : async active-low reset
//   btn_run   : raw button, each press toggles STOP/RUN
//   btn_dir   : raw button, each press toggles direction
//   enable    : one-cycle step strobe, every TICK_DIV
//   direction : 0 = up, 1 = down
//   running   : 1 in RUN, 0 in STOP
module count_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clki,
  input  logic reset_n,
  input  logic btn_run,
  input  logic btn_dir,
  output logic enable,
  output logic direction,
  output logic running
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] DEB_LAST =
    CW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] TICK_LAST =
    PW'(TICK_DIV - 1);

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  // bit 0 = run button, bit 1 = dir button
  logic [1:0]    sy1;
  logic [1:0]    sy2;
  logic [1:0]    deb;
  logic [1:0]    deb_d;
  logic [1:0]    press;
  logic [CW-1:0] cnt [2];

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic          en_nxt;
  logic          dir_nxt;
  logic          run_ev;
  logic          dir_ev;

  // The counter flips deb_state on the edge that
  // would bring it to DEB_CYCLES, so it never has
  // to hold that value itself.
  always_ff @(posedge clki or negedge reset_n) begin
    if (!reset_n) begin
      sy1    <= '0;
      sy2    <= '0;
      deb    <= '0;
      deb_d  <= '0;
      press  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sy1   <= {btn_dir, btn_run};
      sy2   <= sy1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 2; i++) begin
        if (sy2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          deb[i] <= sy2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign run_ev = press[0];
  assign dir_ev = press[1];

  always_ff @(posedge clki or negedge reset_n) begin
    if (!reset_n) state <= STOP;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      STOP: if (run_ev) state_nxt = RUN;
      RUN:  if (run_ev) state_nxt = STOP;
    endcase
  end

  // Any press restarts the prescaler from 0 and
  // swallows a strobe due on the same edge, so the
  // direction never moves under a live strobe.
  always_comb begin
    presc_nxt = '0;
    en_nxt    = 1'b0;
    dir_nxt   = direction ^ dir_ev;
    if (state == RUN && !run_ev && !dir_ev) begin
      if (presc == TICK_LAST) en_nxt = 1'b1;
      else presc_nxt = presc + PW'(1);
    end
  end

  always_ff @(posedge clki or negedge reset_n) begin
    if (!reset_n) begin
      presc     <= '0;
      enable    <= 1'b0;
      direction <= 1'b0;
    end else begin
      presc     <= presc_nxt;
      enable    <= en_nxt;
      direction <= dir_nxt;
    end
  end

  assign running = (state == RUN);

endmodule
